// File: rtl/mac_hdr_extract.sv
// mac_hdr_extract
//   Receive-side header stage in front of the MAC lookup block. Skips the
//   preamble, captures destination and source MAC addresses, issues one lookup
//   request per frame and publishes the returned port as a one-cycle result.
//   Runt frames and frames arriving while a lookup is outstanding are counted.
//
// Ports
//   sys_clk, sys_rst_n      clock, synchronous active-low reset
//   rx_dv, rx_data          GMII-style receive byte stream
//   req, dest_mac, src_mac  lookup request (held until ack) and its key
//   ack, forward_port       lookup acknowledge and result (sampled on accept)
//   fwd_valid, fwd_port,    one-cycle result pulse; fwd_timeout marks a
//   fwd_timeout             FloodPort substitution after a lookup timeout
//   runt_cnt, drop_cnt      saturating event counters
module mac_hdr_extract #(
  parameter logic [15:0] TimeoutCycles = 16'd1024,
  parameter logic [4:0]  FloodPort     = 5'b11111
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        rx_dv,
  input  logic [7:0]  rx_data,
  output logic        req,
  output logic [47:0] src_mac,
  output logic [47:0] dest_mac,
  input  logic        ack,
  input  logic [4:0]  forward_port,
  output logic        fwd_valid,
  output logic [4:0]  fwd_port,
  output logic        fwd_timeout,
  output logic [15:0] runt_cnt,
  output logic [15:0] drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_DEST, S_SRC, S_LOOKUP, S_SKIP
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [47:0] dest_mac_q, dest_mac_d, src_mac_q, src_mac_d;
  logic        req_q, req_d;
  logic        fwd_valid_q, fwd_valid_d;
  logic [4:0]  fwd_port_q, fwd_port_d;
  logic        fwd_timeout_q, fwd_timeout_d;
  logic [15:0] runt_cnt_q, runt_cnt_d, drop_cnt_q, drop_cnt_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;
  logic        drop_seen_q, drop_seen_d;
  logic        rx_dv_prev_q;

  logic accept, timeout, lookup_done, rx_start;

  // Accept has priority: timeout only matters when no ack arrives that cycle.
  assign accept      = (state_q == S_LOOKUP) && req_q && ack;
  assign timeout     = (state_q == S_LOOKUP) && (tmo_cnt_q == TimeoutCycles - 16'd1);
  assign lookup_done = accept || timeout;
  assign rx_start    = rx_dv && !rx_dv_prev_q;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // State register (plus all registered outputs/datapath)
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      dest_mac_q    <= '0;
      src_mac_q     <= '0;
      req_q         <= 1'b0;
      fwd_valid_q   <= 1'b0;
      fwd_port_q    <= '0;
      fwd_timeout_q <= 1'b0;
      runt_cnt_q    <= '0;
      drop_cnt_q    <= '0;
      tmo_cnt_q     <= '0;
      drop_seen_q   <= 1'b0;
      rx_dv_prev_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      dest_mac_q    <= dest_mac_d;
      src_mac_q     <= src_mac_d;
      req_q         <= req_d;
      fwd_valid_q   <= fwd_valid_d;
      fwd_port_q    <= fwd_port_d;
      fwd_timeout_q <= fwd_timeout_d;
      runt_cnt_q    <= runt_cnt_d;
      drop_cnt_q    <= drop_cnt_d;
      tmo_cnt_q     <= tmo_cnt_d;
      drop_seen_q   <= drop_seen_d;
      rx_dv_prev_q  <= rx_dv;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PRE: begin
        if (!rx_dv)                state_d = S_IDLE;
        else if (rx_data == 8'h55) state_d = S_PRE;
        else if (rx_data == 8'hD5) state_d = S_DEST;
        else                       state_d = S_SKIP;
      end
      S_DEST: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (idx_q == 3'd5)  state_d = S_SRC;
      end
      S_SRC: begin
        if (!rx_dv)              state_d = S_IDLE;
        else if (idx_q == 3'd5)  state_d = S_LOOKUP;
      end
      S_LOOKUP: begin
        // A frame that began mid-lookup is never parsed, even if it ended.
        if (lookup_done)
          state_d = (rx_dv || drop_seen_q) ? S_SKIP : S_IDLE;
      end
      S_SKIP:  if (!rx_dv) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    idx_d         = idx_q;
    dest_mac_d    = dest_mac_q;
    src_mac_d     = src_mac_q;
    req_d         = req_q;
    fwd_valid_d   = 1'b0;
    fwd_port_d    = fwd_port_q;
    fwd_timeout_d = fwd_timeout_q;
    runt_cnt_d    = runt_cnt_q;
    drop_cnt_d    = drop_cnt_q;
    tmo_cnt_d     = tmo_cnt_q;
    drop_seen_d   = drop_seen_q;
    case (state_q)
      S_IDLE, S_PRE: idx_d = '0;
      S_DEST: begin
        if (!rx_dv) begin
          runt_cnt_d = sat_inc(runt_cnt_q);
        end else begin
          dest_mac_d = {dest_mac_q[39:0], rx_data};
          idx_d      = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
        end
      end
      S_SRC: begin
        if (!rx_dv) begin
          runt_cnt_d = sat_inc(runt_cnt_q);
        end else begin
          src_mac_d = {src_mac_q[39:0], rx_data};
          idx_d     = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
          if (idx_q == 3'd5) begin
            req_d       = 1'b1;
            tmo_cnt_d   = '0;
            drop_seen_d = 1'b0;
          end
        end
      end
      S_LOOKUP: begin
        if (rx_start) begin
          drop_cnt_d  = sat_inc(drop_cnt_q);
          drop_seen_d = 1'b1;
        end
        if (accept) begin
          req_d         = 1'b0;
          fwd_valid_d   = 1'b1;
          fwd_port_d    = forward_port;
          fwd_timeout_d = 1'b0;
        end else if (timeout) begin
          req_d         = 1'b0;
          fwd_valid_d   = 1'b1;
          fwd_port_d    = FloodPort;
          fwd_timeout_d = 1'b1;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: ;
    endcase
  end

  assign req         = req_q;
  assign dest_mac    = dest_mac_q;
  assign src_mac     = src_mac_q;
  assign fwd_valid   = fwd_valid_q;
  assign fwd_port    = fwd_port_q;
  assign fwd_timeout = fwd_timeout_q;
  assign runt_cnt    = runt_cnt_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_mac_hdr_extract.sv
// Directed bench for mac_hdr_extract (TimeoutCycles = 16).
module tb_mac_hdr_extract;
  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        ack = 1'b0;
  logic [4:0]  forward_port = 5'd0;
  logic        req, fwd_valid, fwd_timeout;
  logic [47:0] src_mac, dest_mac;
  logic [4:0]  fwd_port;
  logic [15:0] runt_cnt, drop_cnt;

  mac_hdr_extract #(.TimeoutCycles(16'd16), .FloodPort(5'b11111)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .rx_dv(rx_dv), .rx_data(rx_data),
    .req(req), .src_mac(src_mac), .dest_mac(dest_mac), .ack(ack),
    .forward_port(forward_port), .fwd_valid(fwd_valid), .fwd_port(fwd_port),
    .fwd_timeout(fwd_timeout), .runt_cnt(runt_cnt), .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  initial forever begin @(posedge sys_clk); cyc++; end

  // ack model: 0 = tied high, <0 = never, d>0 = ack in the (d+1)th req cycle
  int ack_delay = 0;
  initial begin : ack_gen
    int age;
    age = 0;
    forever begin
      @(negedge sys_clk);
      if (req) age++; else age = 0;
      if (ack_delay == 0)     ack = 1'b1;
      else if (ack_delay < 0) ack = 1'b0;
      else                    ack = req && (age > ack_delay);
    end
  end

  // Observation: cumulative counts, snapshot at first req cycle and at fwd_valid
  int          req_total = 0, fv_total = 0, first_req_cyc = 0, fwd_cyc = 0, mac_unstable = 0;
  logic [47:0] cap_dest = '0, cap_src = '0;
  logic [4:0]  cap_port = '0;
  logic        cap_to = 1'b0, req_seen = 1'b0;
  initial forever begin
    @(negedge sys_clk);
    if (req) begin
      req_total++;
      if (!req_seen) begin
        first_req_cyc = cyc; cap_dest = dest_mac; cap_src = src_mac;
      end else if (dest_mac !== cap_dest || src_mac !== cap_src) mac_unstable++;
    end
    req_seen = req;
    if (fwd_valid) begin
      fv_total++; fwd_cyc = cyc; cap_port = fwd_port; cap_to = fwd_timeout;
    end
  end

  typedef struct {
    int npre; logic [47:0] dst; logic [47:0] src; logic [4:0] fp; int dly;
    int exp_req; logic [4:0] exp_port; logic exp_to;
  } vec_t;
  vec_t vecs[6];

  int n_tests = 0, n_fail = 0;
  int sfd_cyc = 0, b_req = 0, b_fv = 0;
  logic [15:0] b_runt = '0, b_drop = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic drive(input logic dv, input logic [7:0] d);
    rx_dv = dv; rx_data = d; tick();
  endtask

  task automatic send_frame(input int npre, input logic [47:0] dst, input logic [47:0] src,
                            input int plen, input int gap);
    for (int i = 0; i < npre; i++) drive(1'b1, 8'h55);
    sfd_cyc = cyc;
    drive(1'b1, 8'hD5);
    for (int i = 0; i < 6; i++) drive(1'b1, dst[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) drive(1'b1, src[47-8*i -: 8]);
    for (int i = 0; i < plen; i++) drive(1'b1, 8'(i + 8'h30));
    for (int i = 0; i < gap; i++) drive(1'b0, 8'h00);
  endtask

  // Preamble + SFD followed by only nhdr header bytes, then idle.
  task automatic send_partial(input int nhdr);
    for (int i = 0; i < 7; i++) drive(1'b1, 8'h55);
    drive(1'b1, 8'hD5);
    for (int i = 0; i < nhdr; i++) drive(1'b1, 8'(i + 8'h40));
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00);
  endtask

  task automatic snap();
    b_req = req_total; b_fv = fv_total; b_runt = runt_cnt; b_drop = drop_cnt;
  endtask

  initial begin
    //                 npre dst                src                fp     dly exp_req port    to
    vecs[0] = '{7, 48'h010203040506, 48'h0A0B0C0D0E0F, 5'd2,  0,  1,  5'd2,  1'b0};
    vecs[1] = '{7, 48'h010203040506, 48'h0A0B0C0D0E0F, 5'd2, -1, 16,  5'd31, 1'b1};
    vecs[2] = '{7, 48'hFFFFFFFFFFFF, 48'h001122334455, 5'd17, 3,  4,  5'd17, 1'b0};
    vecs[3] = '{7, 48'h112233445566, 48'h778899AABBCC, 5'd6, 15, 16,  5'd6,  1'b0};
    vecs[4] = '{1, 48'hA1A2A3A4A5A6, 48'hB1B2B3B4B5B6, 5'd30,14, 15,  5'd30, 1'b0};
    vecs[5] = '{0, 48'h0000000000FF, 48'hFF0000000000, 5'd0,  0,  1,  5'd0,  1'b0};

    // Reset state
    tick(); tick(); tick();
    chk("rst_req", req, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_fwd_port", fwd_port, 0);
    chk("rst_fwd_timeout", fwd_timeout, 0);
    chk("rst_macs", {dest_mac, src_mac} == '0, 1);
    chk("rst_cnts", {runt_cnt, drop_cnt}, 0);
    sys_rst_n = 1'b1;
    tick(); tick();

    // Table-driven good frames: latency, capture, accept/timeout/boundary
    for (int v = 0; v < 6; v++) begin
      snap();
      forward_port = vecs[v].fp; ack_delay = vecs[v].dly;
      tick();
      send_frame(vecs[v].npre, vecs[v].dst, vecs[v].src, 46, 6);
      chk($sformatf("v%0d_req_cycles", v), req_total - b_req, vecs[v].exp_req);
      chk($sformatf("v%0d_req_latency", v), first_req_cyc - sfd_cyc, 13);
      chk($sformatf("v%0d_dest", v), cap_dest, vecs[v].dst);
      chk($sformatf("v%0d_src", v), cap_src, vecs[v].src);
      chk($sformatf("v%0d_fv_count", v), fv_total - b_fv, 1);
      chk($sformatf("v%0d_fv_latency", v), fwd_cyc - sfd_cyc, 13 + vecs[v].exp_req);
      chk($sformatf("v%0d_port", v), cap_port, vecs[v].exp_port);
      chk($sformatf("v%0d_timeout", v), cap_to, vecs[v].exp_to);
    end
    chk("mac_stable_in_lookup", mac_unstable, 0);

    // Runts: end in SRC, in DEST, right after SFD
    ack_delay = 0; forward_port = 5'd3;
    snap();
    send_partial(10);
    chk("runt_src_cnt", runt_cnt, b_runt + 16'd1);
    send_partial(2);
    chk("runt_dest_cnt", runt_cnt, b_runt + 16'd2);
    send_partial(0);
    chk("runt_sfd_cnt", runt_cnt, b_runt + 16'd3);
    chk("runt_no_req", req_total - b_req, 0);
    chk("runt_no_fv", fv_total - b_fv, 0);
    send_frame(7, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, 46, 6);
    chk("post_runt_fv", fv_total - b_fv, 1);
    chk("post_runt_port", cap_port, 3);
    chk("post_runt_dest", cap_dest, 48'h0C0C0C0C0C0C);

    // Drop: frame 2 starts while frame 1's lookup is outstanding
    ack_delay = 10; forward_port = 5'd9;
    tick();
    snap();
    send_frame(7, 48'hAAAAAAAAAA01, 48'hBBBBBBBBBB01, 2, 2);
    send_frame(7, 48'hAAAAAAAAAA02, 48'hBBBBBBBBBB02, 30, 4);
    chk("drop_cnt", drop_cnt, b_drop + 16'd1);
    chk("drop_req_cycles", req_total - b_req, 11);
    chk("drop_fv_count", fv_total - b_fv, 1);
    chk("drop_port", cap_port, 9);
    chk("drop_dest_frame1", cap_dest, 48'hAAAAAAAAAA01);
    ack_delay = 0; forward_port = 5'd12;
    tick();
    send_frame(7, 48'hAAAAAAAAAA03, 48'hBBBBBBBBBB03, 46, 6);
    chk("frame3_fv_count", fv_total - b_fv, 2);
    chk("frame3_dest", cap_dest, 48'hAAAAAAAAAA03);
    chk("frame3_port", cap_port, 12);
    chk("frame3_drop_unchanged", drop_cnt, b_drop + 16'd1);

    // Bad preamble -> SKIP; short preamble-only burst -> IDLE, nothing counted
    snap();
    drive(1'b1, 8'h55); drive(1'b1, 8'h55); drive(1'b1, 8'hAA); drive(1'b1, 8'hD5);
    for (int i = 0; i < 14; i++) drive(1'b1, 8'(i));
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'h55); drive(1'b1, 8'h55);
    for (int i = 0; i < 3; i++) drive(1'b0, 8'h00);
    drive(1'b1, 8'h12); drive(1'b1, 8'hD5);
    for (int i = 0; i < 14; i++) drive(1'b1, 8'(i));
    for (int i = 0; i < 4; i++) drive(1'b0, 8'h00);
    chk("skip_no_req", req_total - b_req, 0);
    chk("skip_runt_same", runt_cnt, b_runt);
    chk("skip_drop_same", drop_cnt, b_drop);

    // Reset while req is high
    ack_delay = -1;
    tick();
    snap();
    send_frame(7, 48'h123456789ABC, 48'hCBA987654321, 0, 3);
    chk("prerst_req_high", req, 1);
    sys_rst_n = 1'b0;
    tick();
    sys_rst_n = 1'b1;
    chk("rst_mid_req", req, 0);
    chk("rst_mid_runt", runt_cnt, 0);
    chk("rst_mid_drop", drop_cnt, 0);
    chk("rst_mid_dest", dest_mac, 0);
    for (int i = 0; i < 24; i++) tick();
    chk("rst_mid_no_fv", fv_total - b_fv, 0);
    ack_delay = 0; forward_port = 5'd4;
    tick();
    send_frame(7, 48'h665544332211, 48'h0F0E0D0C0B0A, 46, 6);
    chk("post_rst_fv", fv_total - b_fv, 1);
    chk("post_rst_port", cap_port, 4);
    chk("post_rst_src", cap_src, 48'h0F0E0D0C0B0A);
    chk("mac_stable_final", mac_unstable, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mac_hdr_extract.md
Name: mac_hdr_extract

Overview:
- Receive-side header stage that sits directly upstream of the MAC lookup block.
- Watches one GMII-style receive byte stream, skips the preamble, and captures the 48-bit destination and source MAC addresses.
- Issues one lookup request per frame on the req/ack interface and publishes the returned forward port as a one-cycle result to the downstream queueing/forwarding logic.
- Also counts runt frames and frames dropped while a lookup is still outstanding.

Parameters:
- TimeoutCycles, 16'd1024, maximum cycles req may stay high without ack before the block gives up and floods.
- FloodPort, 5'b11111, forward port reported on lookup timeout (all-ports/broadcast code).

Ports:
- sys_clk  input  1  single clock; all logic on rising edge.
- sys_rst_n  input  1  reset, synchronous, active-low.
- rx_dv  input  1  receive data valid.
- rx_data  input  8  receive byte, valid when rx_dv=1.
- req  output  1  lookup request, held until accepted.
- src_mac  output  48  captured source MAC, first received byte in [47:40].
- dest_mac  output  48  captured destination MAC, first received byte in [47:40].
- ack  input  1  lookup acknowledge; accepted when req=1 and ack=1 in the same cycle.
- forward_port  input  5  lookup result, sampled in the accept cycle.
- fwd_valid  output  1  one-cycle pulse: result available.
- fwd_port  output  5  forward port, valid with fwd_valid.
- fwd_timeout  output  1  qualifies fwd_valid; high if the port was forced to FloodPort.
- runt_cnt  output  16  saturating count of frames ending inside the MAC header.
- drop_cnt  output  16  saturating count of frames started during LOOKUP.

Behaviour:

Reset (sys_rst_n=0 at a clock edge):
- State goes to IDLE.
- req=0, fwd_valid=0, fwd_timeout=0, fwd_port=0, src_mac=0, dest_mac=0, runt_cnt=0, drop_cnt=0.
- Reset mid-frame or mid-lookup abandons the frame. No fwd_valid is produced for it.

State machine (one state register; all outputs registered):
- IDLE:
  - rx_dv=1 and rx_data=8'h55 -> PRE.
  - rx_dv=1 and rx_data=8'hD5 -> DEST, byte index=0.
  - rx_dv=1 and any other byte -> SKIP.
- PRE:
  - rx_dv=0 -> IDLE, no count.
  - rx_data=8'h55 -> stay in PRE.
  - rx_data=8'hD5 -> DEST, byte index=0.
  - any other byte -> SKIP.
- DEST:
  - Each cycle with rx_dv=1 shifts rx_data into dest_mac.
  - After the 6th byte -> SRC.
- SRC:
  - Same as DEST, shifting into src_mac.
  - After the 6th byte -> LOOKUP, and req=1 from the next cycle.
- DEST/SRC with rx_dv=0 (runt):
  - -> IDLE, runt_cnt+1 (saturate at 16'hFFFF).
  - req is never raised for that frame.
- LOOKUP:
  - req=1. src_mac and dest_mac are held stable.
  - Timeout counter starts at 0 and increments each cycle with no accept.
  - Accept (ack=1): req falls next cycle; fwd_valid=1, fwd_port=forward_port, fwd_timeout=0 for exactly one cycle.
  - Counter reaches TimeoutCycles-1 without accept: req falls; fwd_valid=1, fwd_port=FloodPort, fwd_timeout=1.
  - Accept and timeout in the same cycle: the accept wins.
  - Exit: -> SKIP if rx_dv=1 in the exit cycle or if a new frame started during LOOKUP, else -> IDLE.
- SKIP:
  - Wait for rx_dv=0, then -> IDLE.

Timing:
- SFD byte at cycle N.
- dest bytes at N+1..N+6; src bytes at N+7..N+12.
- req=1 at N+13.
- With ack=1 at N+13: fwd_valid at N+14 and req=0 at N+14.

Drop counting:
- In LOOKUP, a 0->1 transition of rx_dv (previous-cycle rx_dv registered) increments drop_cnt, saturating.
- That frame is not parsed.

Other rules:
- rx_dv gaps are not allowed inside a frame; any rx_dv=0 ends the frame.
- A frame may end (rx_dv=0) during LOOKUP with no effect on the outstanding lookup.

Test Plan:
1. Frame with 7x8'h55, 8'hD5, dest 01:02:03:04:05:06, src 0A:0B:0C:0D:0E:0F, 46 payload bytes; ack tied 1, forward_port=5'd2 -> req high exactly 1 cycle at SFD+13 with dest_mac=48'h010203040506 and src_mac=48'h0A0B0C0D0E0F; fwd_valid at SFD+14 with fwd_port=2 and fwd_timeout=0.
2. Same frame, ack held 0 with TimeoutCycles=16 -> req high 16 cycles; then one fwd_valid with fwd_port=5'b11111 and fwd_timeout=1; state returns to IDLE after rx_dv falls.
3. rx_dv drops after the 4th src byte -> runt_cnt=1, req never asserted; the next good frame is processed normally.
4. ack delayed 200 cycles while frame 1 ends and frame 2 starts at cycle 150 -> drop_cnt=1, single fwd_valid for frame 1, frame 2 fully skipped; frame 3 is parsed normally.
5. Frame starting 8'h55, 8'h55, 8'hAA -> SKIP until rx_dv=0; no req, counters unchanged.
6. sys_rst_n low for 1 cycle while req=1 -> req=0, counters 0 the next cycle; no fwd_valid; the next frame is processed normally.
